// File: rtl/ram_rd_arb.sv
// ram_rd_arb: shares one RAM read port between NB_REQ requesters.
//
// A read is granted only while the requester still holds a credit, i.e. a
// free slot in its private return FIFO. Returning RAM data is therefore
// always accepted and the RAM is never back-pressured.
//
// Build option:
//   RAM_RD_ARB_RR_EN  defined   -> round-robin arbitration (pointer register)
//                     undefined -> fixed priority, lowest index wins
//
// Ports:
//   clk, s_rst_n                 clock, synchronous active-low reset
//   rd_vld/rd_rdy/rd_add         per-requester address channel (rd_rdy = grant)
//   rd_data_vld/rd_data_rdy/rd_data  per-requester FWFT return channel
//   ram_ren/ram_add              registered RAM read request
//   ram_data                     RAM data, valid RAM_LATENCY cycles after ram_ren
//   ram_req_id                   requester index behind the current ram_ren
module ram_rd_arb #(
  parameter int unsigned NB_REQ      = 2,
  parameter int unsigned ADD_W       = 8,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned RAM_LATENCY = 2,
  parameter int unsigned BUF_DEPTH   = RAM_LATENCY + 2
) (
  input  logic                       clk,
  input  logic                       s_rst_n,
  input  logic [NB_REQ-1:0]          rd_vld,
  output logic [NB_REQ-1:0]          rd_rdy,
  input  logic [NB_REQ*ADD_W-1:0]    rd_add,
  output logic [NB_REQ-1:0]          rd_data_vld,
  input  logic [NB_REQ-1:0]          rd_data_rdy,
  output logic [NB_REQ*DATA_W-1:0]   rd_data,
  output logic                       ram_ren,
  output logic [ADD_W-1:0]           ram_add,
  input  logic [DATA_W-1:0]          ram_data,
  output logic [$clog2(NB_REQ)-1:0]  ram_req_id
);

  localparam int unsigned ID_W  = $clog2(NB_REQ);
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  logic [CNT_W-1:0]  credit [NB_REQ];
  logic [NB_REQ-1:0] eligible;
  logic [NB_REQ-1:0] grant;
  logic [NB_REQ-1:0] push;
  logic [NB_REQ-1:0] pop;
  logic [ID_W-1:0]   winner;
  logic [ADD_W-1:0]  win_add;

  logic [RAM_LATENCY-1:0]           sr_vld;
  logic [RAM_LATENCY-1:0][ID_W-1:0] sr_id;

  logic [DATA_W-1:0] mem    [NB_REQ][BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr [NB_REQ];
  logic [PTR_W-1:0]  rd_ptr [NB_REQ];
  logic [CNT_W-1:0]  fill   [NB_REQ];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Grants are suppressed while reset is asserted so nothing is launched
  // during reset even if a requester already drives rd_vld.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NB_REQ; i++)
      eligible[i] = s_rst_n & rd_vld[i] & (credit[i] != '0);
  end

`ifdef RAM_RD_ARB_RR_EN
  logic [ID_W-1:0] rr_ptr;
  int unsigned     cand;

  always_comb begin
    grant  = '0;
    winner = '0;
    cand   = 0;
    for (int unsigned k = 0; k < NB_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % NB_REQ;
      if (grant == '0 && eligible[cand]) begin
        grant[cand] = 1'b1;
        winner      = ID_W'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!s_rst_n)
      rr_ptr <= '0;
    else if (grant != '0)
      rr_ptr <= (winner == ID_W'(NB_REQ - 1)) ? '0 : winner + ID_W'(1);
  end
`else
  always_comb begin
    grant  = '0;
    winner = '0;
    for (int unsigned k = 0; k < NB_REQ; k++) begin
      if (grant == '0 && eligible[k]) begin
        grant[k] = 1'b1;
        winner   = ID_W'(k);
      end
    end
  end
`endif

  assign rd_rdy = grant;

  always_comb begin
    win_add = '0;
    for (int unsigned i = 0; i < NB_REQ; i++)
      if (grant[i]) win_add = rd_add[i*ADD_W +: ADD_W];
  end

  // Request stage: address and id hold their last values when idle.
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      ram_ren    <= 1'b0;
      ram_add    <= '0;
      ram_req_id <= '0;
    end else begin
      ram_ren <= (grant != '0);
      if (grant != '0) begin
        ram_add    <= win_add;
        ram_req_id <= winner;
      end
    end
  end

  // In-flight tracker: the tail lines up with the cycle ram_data is valid.
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      sr_vld <= '0;
      sr_id  <= '0;
    end else begin
      sr_vld[0] <= ram_ren;
      sr_id[0]  <= ram_req_id;
      for (int unsigned k = 1; k < RAM_LATENCY; k++) begin
        sr_vld[k] <= sr_vld[k-1];
        sr_id[k]  <= sr_id[k-1];
      end
    end
  end

  always_comb begin
    push = '0;
    pop  = '0;
    for (int unsigned i = 0; i < NB_REQ; i++) begin
      push[i] = sr_vld[RAM_LATENCY-1] && (sr_id[RAM_LATENCY-1] == ID_W'(i));
      pop[i]  = rd_data_vld[i] & rd_data_rdy[i];
    end
  end

  // Credits: grant and pop in the same cycle cancel out.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NB_REQ; i++) begin
      if (!s_rst_n)
        credit[i] <= CNT_W'(BUF_DEPTH);
      else if (grant[i] && !pop[i])
        credit[i] <= credit[i] - CNT_W'(1);
      else if (pop[i] && !grant[i])
        credit[i] <= credit[i] + CNT_W'(1);
    end
  end

  // Return FIFOs, first-word fall-through.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NB_REQ; i++) begin
      if (!s_rst_n) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        fill[i]   <= '0;
      end else begin
        if (push[i]) begin
          mem[i][wr_ptr[i]] <= ram_data;
          wr_ptr[i]         <= ptr_inc(wr_ptr[i]);
        end
        if (pop[i])
          rd_ptr[i] <= ptr_inc(rd_ptr[i]);
        if (push[i] && !pop[i])
          fill[i] <= fill[i] + CNT_W'(1);
        else if (pop[i] && !push[i])
          fill[i] <= fill[i] - CNT_W'(1);
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (s_rst_n) begin
      for (int unsigned i = 0; i < NB_REQ; i++)
        assert (!(push[i] && fill[i] == CNT_W'(BUF_DEPTH)))
          else $fatal(1, "ram_rd_arb: return buffer %0d overflow", i);
    end
  end
`endif

  always_comb begin
    rd_data     = '0;
    rd_data_vld = '0;
    for (int unsigned i = 0; i < NB_REQ; i++) begin
      rd_data_vld[i]              = (fill[i] != '0);
      rd_data[i*DATA_W +: DATA_W] = mem[i][rd_ptr[i]];
    end
  end

endmodule

// File: tb/tb_ram_rd_arb.sv
// Directed testbench for ram_rd_arb (NB_REQ=2, RAM_LATENCY=2, BUF_DEPTH=4).
// The RAM model returns {24'hA5A500, address} RAM_LATENCY cycles after ram_ren.
module tb_ram_rd_arb;

  localparam int unsigned NB_REQ      = 2;
  localparam int unsigned ADD_W       = 8;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned RAM_LATENCY = 2;
  localparam int unsigned BUF_DEPTH   = 4;

  logic                     clk = 1'b0;
  logic                     s_rst_n;
  logic [NB_REQ-1:0]        rd_vld;
  logic [NB_REQ-1:0]        rd_rdy;
  logic [NB_REQ*ADD_W-1:0]  rd_add;
  logic [NB_REQ-1:0]        rd_data_vld;
  logic [NB_REQ-1:0]        rd_data_rdy;
  logic [NB_REQ*DATA_W-1:0] rd_data;
  logic                     ram_ren;
  logic [ADD_W-1:0]         ram_add;
  logic [DATA_W-1:0]        ram_data;
  logic [0:0]               ram_req_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_rd_arb #(
    .NB_REQ(NB_REQ), .ADD_W(ADD_W), .DATA_W(DATA_W),
    .RAM_LATENCY(RAM_LATENCY), .BUF_DEPTH(BUF_DEPTH)
  ) dut (
    .clk(clk), .s_rst_n(s_rst_n),
    .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_add(rd_add),
    .rd_data_vld(rd_data_vld), .rd_data_rdy(rd_data_rdy), .rd_data(rd_data),
    .ram_ren(ram_ren), .ram_add(ram_add), .ram_data(ram_data),
    .ram_req_id(ram_req_id)
  );

  // RAM model
  logic [ADD_W-1:0] ram_pipe [RAM_LATENCY];
  always @(posedge clk) begin
    ram_pipe[0] <= ram_add;
    for (int k = 1; k < RAM_LATENCY; k++) ram_pipe[k] <= ram_pipe[k-1];
  end
  assign ram_data = {24'hA5A500, ram_pipe[RAM_LATENCY-1]};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    s_rst_n     = 1'b0;
    rd_vld      = '0;
    rd_data_rdy = '0;
    rd_add      = '0;
    repeat (3) tick();
    s_rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int grants;
    int a;
    int w;
    int seen;
    logic [1:0] exp_rr [4];

    // Reset state
    do_reset();
    settle();
    check("rst_ram_ren", ram_ren, 0);
    check("rst_rd_rdy", rd_rdy, 0);
    check("rst_rd_data_vld", rd_data_vld, 0);
    check("rst_ram_req_id", ram_req_id, 0);
    check("rst_ram_add", ram_add, 0);

    // Single read: req0 reads 0x05
    rd_vld = 2'b01; rd_add[7:0] = 8'h05;
    settle();
    check("single_grant", rd_rdy, 2'b01);
    tick();
    rd_vld = 2'b00;
    check("single_ram_ren", ram_ren, 1);
    check("single_ram_add", ram_add, 8'h05);
    check("single_req_id", ram_req_id, 0);
    check("single_vld_c1", rd_data_vld, 0);
    tick();
    check("single_vld_c2", rd_data_vld, 0);
    check("single_ren_idle", ram_ren, 0);
    tick();
    check("single_vld_c3", rd_data_vld, 0);
    tick();
    check("single_vld_ret", rd_data_vld, 2'b01);
    check("single_data", rd_data[31:0], 32'hA5A5_0005);
    rd_data_rdy = 2'b01;
    tick();
    rd_data_rdy = 2'b00;
    check("single_popped", rd_data_vld, 0);

    // Credit exhaustion
    do_reset();
    a = 0; grants = 0;
    for (int c = 0; c < 10; c++) begin
      rd_vld = 2'b01; rd_add[7:0] = 8'(a);
      settle();
      if (rd_rdy[0]) begin grants++; a++; end
      tick();
    end
    check("exh_grants", grants, 4);
    settle();
    check("exh_blocked", rd_rdy, 2'b00);
    check("exh_vld", rd_data_vld, 2'b01);
    check("exh_head", rd_data[31:0], 32'hA5A5_0000);
    rd_data_rdy = 2'b01;
    settle();
    check("exh_pop_cycle_rdy", rd_rdy, 2'b00);
    tick();
    rd_data_rdy = 2'b00;
    grants = 0;
    for (int c = 0; c < 6; c++) begin
      rd_add[7:0] = 8'(a);
      settle();
      if (rd_rdy[0]) begin grants++; a++; end
      tick();
    end
    check("exh_regrant", grants, 1);
    rd_vld = 2'b00;
    rd_data_rdy = 2'b01;
    for (int e = 1; e <= 4; e++) begin
      w = 0;
      while (!rd_data_vld[0] && w < 10) begin tick(); w++; end
      check("exh_order", rd_data[31:0], 32'hA5A5_0000 | e);
      tick();
    end
    rd_data_rdy = 2'b00;
    settle();
    check("exh_drained", rd_data_vld, 0);

    // Contention
    do_reset();
    rd_data_rdy = 2'b11;
    rd_add = {8'h20, 8'h10};
    rd_vld = 2'b11;
`ifdef RAM_RD_ARB_RR_EN
    exp_rr[0] = 2'b01; exp_rr[1] = 2'b10; exp_rr[2] = 2'b01; exp_rr[3] = 2'b10;
    for (int c = 0; c < 4; c++) begin
      settle();
      check("rr_grant", rd_rdy, exp_rr[c]);
      tick();
      check("rr_req_id", ram_req_id, exp_rr[c][1]);
    end
`else
    exp_rr[0] = 2'b01; exp_rr[1] = 2'b01; exp_rr[2] = 2'b01; exp_rr[3] = 2'b01;
    for (int c = 0; c < 4; c++) begin
      settle();
      check("fp_grant", rd_rdy, exp_rr[c]);
      tick();
      check("fp_req_id", ram_req_id, 0);
      check("fp_ram_add", ram_add, 8'h10);
    end
    rd_vld = 2'b10;
    settle();
    check("fp_req1_grant", rd_rdy, 2'b10);
    tick();
    check("fp_req1_id", ram_req_id, 1);
    check("fp_req1_add", ram_add, 8'h20);
`endif
    rd_vld = 2'b00;

    // Blocked requester bypass
    do_reset();
    rd_add = {8'h31, 8'h30};
    rd_vld = 2'b01;
    for (int c = 0; c < 4; c++) begin
      settle();
      check("byp_req0_grant", rd_rdy, 2'b01);
      tick();
    end
    rd_vld = 2'b11;
    settle();
    check("byp_req1_grant", rd_rdy, 2'b10);
    tick();
    rd_vld = 2'b00;
    check("byp_no_bubble", ram_ren, 1);
    check("byp_req_id", ram_req_id, 1);
    check("byp_ram_add", ram_add, 8'h31);

    // Simultaneous grant and pop at credit 2
    do_reset();
    rd_vld = 2'b01; rd_add[7:0] = 8'h40;
    settle();
    tick();
    rd_add[7:0] = 8'h41;
    tick();
    rd_vld = 2'b00;
    w = 0;
    while (!rd_data_vld[0] && w < 10) begin tick(); w++; end
    check("gp_head", rd_data[31:0], 32'hA5A5_0040);
    rd_vld = 2'b01; rd_add[7:0] = 8'h42; rd_data_rdy = 2'b01;
    settle();
    check("gp_grant", rd_rdy, 2'b01);
    tick();
    rd_data_rdy = 2'b00;
    grants = 0;
    for (int c = 0; c < 6; c++) begin
      rd_add[7:0] = 8'(8'h43 + grants);
      settle();
      if (rd_rdy[0]) grants++;
      tick();
    end
    check("gp_credit_held", grants, 2);
    rd_vld = 2'b00;

    // Reset mid-flight
    do_reset();
    rd_vld = 2'b01; rd_add[7:0] = 8'h07;
    settle();
    tick();
    rd_vld = 2'b00;
    check("rmf_ram_ren", ram_ren, 1);
    tick();
    s_rst_n = 1'b0;
    tick();
    s_rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (rd_data_vld != 2'b00) seen++;
      tick();
    end
    check("rmf_no_vld", seen, 0);
    grants = 0;
    rd_vld = 2'b01;
    for (int c = 0; c < 8; c++) begin
      settle();
      if (rd_rdy[0]) grants++;
      tick();
    end
    rd_vld = 2'b00;
    check("rmf_credits", grants, BUF_DEPTH);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
